// File: rtl/control_signals.sv
// Shared types and constants for the multi-cycle controller.
// The timeout watchdog in multicycle_ctrl is built only when CTRL_TIMEOUT_EN is defined.
package control_signals;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } Ctrl_State_t;

    // Instruction classes resolved in DECODE; NOP is the post-reset value
    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_LD      = 4'd1,
        CLS_SD      = 4'd2,
        CLS_ADD     = 4'd3,
        CLS_SUB     = 4'd4,
        CLS_AND     = 4'd5,
        CLS_OR      = 4'd6,
        CLS_BEQ     = 4'd7,
        CLS_ILLEGAL = 4'd8
    } Instr_Class_t;

    // Second ALU operand select
    typedef enum logic {
        ALU_SRC_REG = 1'b0,
        ALU_SRC_IMM = 1'b1
    } Alu_Src_t;

    // ALU operation select
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } Alu_Operation_t;

    // Register file write-data select
    typedef enum logic {
        REG_SRC_ALU = 1'b0,
        REG_SRC_MEM = 1'b1
    } Reg_Data_Src_t;

    // Opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True for classes that finish with a register writeback of the ALU result
    function automatic logic is_rtype(input Instr_Class_t cls);
        return (cls == CLS_ADD) || (cls == CLS_SUB) ||
               (cls == CLS_AND) || (cls == CLS_OR);
    endfunction

endpackage

// File: rtl/instr_classifier.sv
// Purely combinational mapping of opcode/funct3/funct7 to an instruction class.
// Anything not explicitly recognised is reported as CLS_ILLEGAL.
module instr_classifier
    import control_signals::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    output Instr_Class_t o_class
);

    // Decode the encoding; R-type and branch also qualify on funct fields
    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OPC_LOAD:  o_class = CLS_LD;
            OPC_STORE: o_class = CLS_SD;
            OPC_RTYPE: begin
                if (i_funct3 == F3_ADD_SUB && i_funct7 == F7_BASE) begin
                    o_class = CLS_ADD;
                end else if (i_funct3 == F3_ADD_SUB && i_funct7 == F7_ALT) begin
                    o_class = CLS_SUB;
                end else if (i_funct3 == F3_AND && i_funct7 == F7_BASE) begin
                    o_class = CLS_AND;
                end else if (i_funct3 == F3_OR && i_funct7 == F7_BASE) begin
                    o_class = CLS_OR;
                end
            end
            OPC_BRANCH: begin
                if (i_funct3 == F3_BEQ) begin
                    o_class = CLS_BEQ;
                end
            end
            default: o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK].
// Illegal encodings park the controller in TRAP until reset.
// Optional: define CTRL_TIMEOUT_EN to add a wait watchdog that traps when an
// instruction fetch or data access goes unacknowledged for MEM_TIMEOUT cycles.
module multicycle_ctrl
    import control_signals::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [6:0]     opcode_in,
    input  logic [2:0]     funct3_in,
    input  logic [6:0]     funct7_in,
    input  logic           imem_ack,
    input  logic           dmem_ack,
    input  logic           zero_in,
    output logic           imem_req,
    output logic           ir_write,
    output logic           pc_inc,
    output logic           pc_branch,
    output Alu_Src_t       alu_src_mux,
    output Alu_Operation_t alu_op,
    output Reg_Data_Src_t  reg_src_mux,
    output logic           mem_read,
    output logic           mem_write,
    output logic           reg_write,
    output logic           halted
);

    Ctrl_State_t  r_state;
    Instr_Class_t r_class;
    Instr_Class_t w_class;
    logic         w_timeout_hit;

    instr_classifier u_classifier (
        .i_opcode (opcode_in),
        .i_funct3 (funct3_in),
        .i_funct7 (funct7_in),
        .o_class  (w_class)
    );

`ifdef CTRL_TIMEOUT_EN
    // Limits above 15 saturate: the 4-bit counter can never count past 15.
    localparam logic [3:0] WAIT_LIMIT = (MEM_TIMEOUT >= 15) ? 4'd15 : 4'(MEM_TIMEOUT);

    logic [3:0] r_wait_cnt;
    logic       w_waiting;

    // Waiting means sitting in a state that needs an ack and not getting it
    assign w_waiting = ((r_state == ST_FETCH) && !imem_ack) ||
                       ((r_state == ST_MEM)   && !dmem_ack);

    // Trap on the cycle whose unacknowledged wait brings the count to the limit
    assign w_timeout_hit = w_waiting &&
                           (({1'b0, r_wait_cnt} + 5'd1) >= {1'b0, WAIT_LIMIT});

    // Saturating wait counter; any ack or leaving the waiting state clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
        end else if (!w_waiting) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != 4'hF) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end
`else
    // No watchdog: fetch and data accesses wait for their ack indefinitely.
    assign w_timeout_hit = 1'b0;
`endif

    // State and class register; acks only matter in the state awaiting them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_class <= CLS_NOP;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout_hit) begin
                        r_state <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    r_class <= w_class;
                    r_state <= (w_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (r_class == CLS_LD || r_class == CLS_SD) begin
                        r_state <= ST_MEM;
                    end else if (is_rtype(r_class)) begin
                        r_state <= ST_WRITEBACK;
                    end else if (r_class == CLS_BEQ) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_TRAP;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_state <= (r_class == CLS_LD) ? ST_WRITEBACK : ST_FETCH;
                    end else if (w_timeout_hit) begin
                        r_state <= ST_TRAP;
                    end
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_TRAP:      r_state <= ST_TRAP;
                default:      r_state <= ST_TRAP;
            endcase
        end
    end

    // Output decode from registered state/class; rst forces the FETCH view
    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        alu_src_mux = ALU_SRC_REG;
        alu_op      = OP_AND;
        reg_src_mux = REG_SRC_ALU;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            imem_req = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                    pc_inc   = imem_ack;
                end
                ST_EXECUTE: begin
                    case (r_class)
                        CLS_LD, CLS_SD: begin
                            alu_op      = OP_ADD;
                            alu_src_mux = ALU_SRC_IMM;
                        end
                        CLS_ADD: alu_op = OP_ADD;
                        CLS_SUB: alu_op = OP_SUB;
                        CLS_AND: alu_op = OP_AND;
                        CLS_OR:  alu_op = OP_OR;
                        CLS_BEQ: begin
                            alu_op    = OP_SUB;
                            pc_branch = zero_in;
                        end
                        default: alu_op = OP_AND;
                    endcase
                end
                ST_MEM: begin
                    alu_op      = OP_ADD;
                    alu_src_mux = ALU_SRC_IMM;
                    mem_read    = (r_class == CLS_LD);
                    mem_write   = (r_class == CLS_SD);
                end
                ST_WRITEBACK: begin
                    reg_write   = 1'b1;
                    reg_src_mux = (r_class == CLS_LD) ? REG_SRC_MEM : REG_SRC_ALU;
                end
                ST_TRAP: halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum cycles to wait for any memory ack before trapping.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports opcode_in, funct3_in and funct7_in, inputs, widths 7/3/7, fields of the instruction register.
REQ-005 SHALL have ports imem_ack, dmem_ack and zero_in, inputs, 1 each: instruction fetch complete, data access complete, ALU result zero.
REQ-006 SHALL have ports imem_req, ir_write, pc_inc and pc_branch, outputs, 1 each: fetch request, IR load, PC+4, PC+imm.
REQ-007 SHALL have ports alu_src_mux (Alu_Src_t), alu_op (Alu_Operation_t) and reg_src_mux (Reg_Data_Src_t), outputs: datapath selects.
REQ-008 SHALL have ports mem_read, mem_write, reg_write and halted, outputs, 1 each; halted means the controller is in TRAP.

Function
REQ-009 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK and TRAP, with all outputs a function of the registered state and the registered class.
REQ-010 FETCH SHALL assert imem_req; on imem_ack it SHALL pulse ir_write and pc_inc for that cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-011 DECODE SHALL last one cycle and register the instruction class: LD (0000011), SD (0100011), ADD/SUB (0110011, f3=000, f7=0000000/0100000), AND (f3=111, f7=0000000), OR (f3=110, f7=0000000), BEQ (1100011, f3=000).
REQ-012 Any other encoding in DECODE SHALL go to TRAP.
REQ-013 EXECUTE SHALL drive alu_op/alu_src_mux as follows: OP_ADD/IMM for LD/SD; OP_ADD, OP_SUB, OP_AND or OP_OR with REG for R-type; OP_SUB/REG for BEQ.
REQ-014 EXECUTE SHALL then go to MEM for LD/SD and to WRITEBACK for R-type.
REQ-015 For BEQ, EXECUTE SHALL assert pc_branch iff zero_in, then go to FETCH.
REQ-016 MEM SHALL hold mem_read (LD) or mem_write (SD), plus alu_src_mux=IMM and alu_op=OP_ADD, until dmem_ack; then LD SHALL go to WRITEBACK and SD to FETCH.
REQ-017 WRITEBACK SHALL assert reg_write for exactly one cycle, with reg_src_mux=MEM for LD and ALU otherwise, then go to FETCH.
REQ-018 Outputs not named for a state SHALL be 0 / ALU_SRC_REG / OP_AND / REG_SRC_ALU.
REQ-019 Latency with single-cycle acks SHALL be: R-type 4 cycles, LD 5, SD 4, BEQ 3.
REQ-020 An ack arriving in a state that does not await it SHALL be ignored.
REQ-021 An ack in the same cycle as rst SHALL be ignored.
REQ-022 TRAP SHALL be sticky until rst, with halted=1 and all other strobes 0.
REQ-023 mem_read and mem_write SHALL never be asserted together.
REQ-024 reg_write SHALL never be asserted outside WRITEBACK.

Reset
REQ-025 On rst at a rising edge, state SHALL become FETCH, the class register NOP, the wait counter 0 and halted 0.
REQ-026 An in-flight fetch or data access SHALL be abandoned, and imem_req SHALL be reasserted the cycle after reset is released.
REQ-027 While rst is high, outputs SHALL reflect FETCH (imem_req=1, all else 0).

Configuration
REQ-028 With CTRL_TIMEOUT_EN defined, a 4-bit saturating wait counter SHALL count cycles in FETCH/MEM without ack, clear on ack or state change, and go to TRAP when it reaches MEM_TIMEOUT.
REQ-029 Without CTRL_TIMEOUT_EN, no counter SHALL exist, FETCH/MEM SHALL wait indefinitely, and TRAP SHALL be reachable only via an illegal encoding.

Structure
REQ-030 Ctrl_State_t, Instr_Class_t and the opcode/funct constants SHALL live in package control_signals, alongside Alu_Src_t, Alu_Operation_t and Reg_Data_Src_t.
REQ-031 Encoding-to-class mapping SHALL be a combinational sub-module, instr_classifier; the FSM and counter SHALL stay in multicycle_ctrl.

Verification
REQ-032 ADD x3,x1,x2 with imem_ack on cycle 1 -> ir_write and pc_inc at cycle 1, alu_op=OP_SUB never, reg_write=1 at cycle 4 only, back in FETCH at cycle 5.
REQ-033 LD with dmem_ack delayed 3 cycles -> mem_read held exactly 4 cycles, reg_write with REG_SRC_MEM one cycle later, total 8 cycles.
REQ-034 BEQ with zero_in=1, then BEQ with zero_in=0 -> pc_branch pulses only in the first EXECUTE, and reg_write/mem_write stay 0 throughout.
REQ-035 Opcode 0010011 (or R-type f3=001) -> TRAP after DECODE, halted=1 held for 20 cycles; rst -> FETCH next cycle.
REQ-036 CTRL_TIMEOUT_EN with MEM_TIMEOUT=15 and no dmem_ack on SD -> mem_write for 15 cycles then TRAP; without the macro -> mem_write held indefinitely.
REQ-037 rst asserted mid-MEM with dmem_ack on the same cycle -> mem_read 0 next cycle, state FETCH, no reg_write.
